// File: rtl/rgmii_pkg.sv
// Shared constants and FSM state type for the RGMII transmit framer and
// the companion CRC logic.
package rgmii_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_POLY_REF  = 32'hEDB88320;
  localparam int          PREAMBLE_LEN  = 7;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    DROP,
    PAD,
    FCS,
    IFG
  } state_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide IEEE 802.3 CRC-32 update in reflected form,
// data consumed LSB first; shared by the TX framer and the RX checker.
module crc32_d8
  import rgmii_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  d,
  output logic [31:0] crc_next
);

  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 8; i++)
      crc_next = (crc_next >> 1) ^ (CRC_POLY_REF & {32{crc_next[0] ^ d[i]}});
  end

endmodule

// File: rtl/rgmii_tx_framer.sv
// RGMII 1000BASE-T transmit framer: preamble/SFD, payload, FCS and IFG onto a
// registered 10-bit ODDR word. Define RGMII_TX_PAD_EN to zero-pad short frames.
module rgmii_tx_framer
  import rgmii_pkg::*;
#(
  parameter int IFG_CYCLES = 12,
  parameter int MIN_FRAME  = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [9:0] q,
  output logic       busy,
  output logic       underrun
);

`ifdef RGMII_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  state_t      r_state, w_next;
  logic [15:0] r_cnt, r_len;
  logic [31:0] r_crc, w_crc_next, w_len_p1;
  logic [7:0]  r_hold, w_byte;
  logic        r_hvld, r_hlast;
  logic [9:0]  r_q;
  logic        w_en, w_er, w_ready, w_underrun, w_crc_en, w_start;
  logic        w_cnt_clr, w_len_inc, w_hvld_clr, w_hold_ld, w_go_pad;

  crc32_d8 u_crc (
    .crc      (r_crc),
    .d        (w_byte),
    .crc_next (w_crc_next)
  );

  assign w_len_p1  = {16'd0, r_len} + 32'd1;
  assign w_go_pad  = PAD_EN && (w_len_p1 < 32'(MIN_FRAME));
  assign w_hold_ld = w_ready && s_valid && (r_state == SFD || r_state == DATA);

  assign s_ready  = w_ready;
  assign underrun = w_underrun;
  assign busy     = (r_state != IDLE);
  assign q        = r_q;

  // Byte selection: payload goes through a one-byte hold register because the
  // first byte is accepted during SFD, one cycle before it can be emitted.
  always_comb begin
    w_next     = r_state;
    w_byte     = 8'h00;
    w_en       = 1'b0;
    w_er       = 1'b0;
    w_ready    = 1'b0;
    w_underrun = 1'b0;
    w_crc_en   = 1'b0;
    w_start    = 1'b0;
    w_cnt_clr  = 1'b0;
    w_len_inc  = 1'b0;
    w_hvld_clr = 1'b0;
    case (r_state)
      IDLE: if (s_valid) begin
        w_next    = PRE;
        w_cnt_clr = 1'b1;
      end
      PRE: begin
        w_en   = 1'b1;
        w_byte = PREAMBLE_BYTE;
        if (r_cnt == 16'(PREAMBLE_LEN - 1)) w_next = SFD;
      end
      SFD: begin
        w_en       = 1'b1;
        w_byte     = SFD_BYTE;
        w_ready    = 1'b1;
        w_start    = 1'b1;
        w_underrun = !s_valid;
        w_next     = DATA;
      end
      DATA: begin
        w_en = 1'b1;
        if (!r_hvld) begin
          w_er   = 1'b1;
          w_next = DROP;
        end else begin
          w_byte    = r_hold;
          w_crc_en  = 1'b1;
          w_len_inc = 1'b1;
          if (r_hlast) begin
            w_hvld_clr = 1'b1;
            w_cnt_clr  = 1'b1;
            w_next     = w_go_pad ? PAD : FCS;
          end else begin
            w_ready = 1'b1;
            if (!s_valid) begin
              w_underrun = 1'b1;
              w_hvld_clr = 1'b1;
            end
          end
        end
      end
      DROP: begin
        w_ready = 1'b1;
        if (s_valid && s_last) begin
          w_next    = IFG;
          w_cnt_clr = 1'b1;
        end
      end
`ifdef RGMII_TX_PAD_EN
      PAD: begin
        w_en      = 1'b1;
        w_crc_en  = 1'b1;
        w_len_inc = 1'b1;
        if (w_len_p1 >= 32'(MIN_FRAME)) begin
          w_next    = FCS;
          w_cnt_clr = 1'b1;
        end
      end
`endif
      FCS: begin
        w_en   = 1'b1;
        w_byte = ~r_crc[{r_cnt[1:0], 3'b000} +: 8];
        if (r_cnt[1:0] == 2'd3) begin
          w_next    = IFG;
          w_cnt_clr = 1'b1;
        end
      end
      IFG: if (r_cnt == 16'(IFG_CYCLES - 1)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output register stage: {TX_EN^TX_ER, TXD[7:4], TX_EN, TXD[3:0]}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 16'd0;
      r_len   <= 16'd0;
      r_crc   <= CRC_INIT;
      r_hvld  <= 1'b0;
      r_hlast <= 1'b0;
      r_q     <= 10'h000;
    end else begin
      r_state <= w_next;
      r_q     <= {w_en ^ w_er, w_byte[7:4], w_en, w_byte[3:0]};
      r_cnt   <= w_cnt_clr ? 16'd0 : r_cnt + 16'd1;
      if (w_start)
        r_len <= 16'd0;
      else if (w_len_inc && r_len != 16'hFFFF)
        r_len <= r_len + 16'd1;
      if (w_start)
        r_crc <= CRC_INIT;
      else if (w_crc_en)
        r_crc <= w_crc_next;
      if (w_hold_ld) begin
        r_hvld  <= 1'b1;
        r_hlast <= s_last;
      end else if (w_hvld_clr) begin
        r_hvld <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hold_ld) r_hold <= s_data;
  end

endmodule
